// File: rtl/bsg_ds_rx_gather.sv
// bsg_ds_rx_gather
// Receive side of the downstream source-synchronous channel. Narrow IO beats
// are gathered into BEATS-wide buffer words. The words are kept in a circular
// buffer addressed by pointers that carry a wrap bit. Groups of CORE_RATIO
// words go to the core through a registered valid/ready output stage. One
// credit token is returned upstream for every TOKEN_EVERY words drained.
//
// Ports:
//   clk            sole clock
//   rst            synchronous, active-high reset
//   io_valid_in    IO beat valid (there is no backpressure toward IO)
//   io_data_in     IO beat data, IO_W bits
//   core_ready     core accepts core_data_out
//   core_valid_out core word valid
//   core_data_out  core word, CORE_W bits; the lowest-addressed buffer word
//                  is in the LSBs
//   io_token_out   one-cycle credit pulse to the upstream side
//   full           buffer full (registered)
//   overflow       sticky dropped-write flag
//
// Optional feature macro: BSG_DS_RX_OVERFLOW_STICKY_EN
//   When it is defined, overflow is set by the first write dropped on full
//   and holds until rst. When it is not defined, overflow is tied to 0. A
//   write that arrives while the buffer is full is dropped in both builds.
module bsg_ds_rx_gather #(
    parameter int IO_W        = 8,
    parameter int BEATS       = 2,
    parameter int DEPTH       = 64,
    parameter int CORE_RATIO  = 2,
    parameter int TOKEN_EVERY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         io_valid_in,
    input  logic [IO_W-1:0]              io_data_in,
    input  logic                         core_ready,
    output logic                         core_valid_out,
    output logic [IO_W*BEATS*CORE_RATIO-1:0] core_data_out,
    output logic                         io_token_out,
    output logic                         full,
    output logic                         overflow
);

    localparam int W      = IO_W * BEATS;
    localparam int CORE_W = W * CORE_RATIO;
    localparam int AW     = $clog2(DEPTH);
    localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TCW    = $clog2(TOKEN_EVERY) + 1;

    // ------------------------------------------------------------------
    // Beat assembler
    // ------------------------------------------------------------------
    logic [BCW-1:0] beat_cnt_reg;
    logic           last_beat;
    logic [W-1:0]   word_in;

    assign last_beat = (beat_cnt_reg == BCW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg <= '0;
        end else if (io_valid_in) begin
            if (last_beat) begin
                beat_cnt_reg <= '0;
            end else begin
                beat_cnt_reg <= beat_cnt_reg + BCW'(1);
            end
        end
    end

    generate
        if (BEATS > 1) begin : g_hold
            localparam int HW = (BEATS - 1) * IO_W;
            logic [HW-1:0] hold_reg;

            // Earlier beats sit below the beat being completed, so the
            // first beat of a word ends up in its LSBs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg <= '0;
                end else if (io_valid_in && !last_beat) begin
                    hold_reg[beat_cnt_reg*IO_W +: IO_W] <= io_data_in;
                end
            end

            assign word_in = {io_data_in, hold_reg};
        end else begin : g_nohold
            assign word_in = io_data_in;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Circular buffer and pointers
    // ------------------------------------------------------------------
    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr_reg;
    logic [AW:0]   rptr_reg;
    logic [AW:0]   wptr_next;
    logic [AW:0]   rptr_next;
    logic [AW:0]   count;
    logic          full_reg;
    logic          wr_en;
    logic          load;
    logic [CORE_W-1:0] rd_word;

    assign count = wptr_reg - rptr_reg;
    // A last beat that meets a full buffer is discarded; the assembler still
    // starts a new word.
    assign wr_en = io_valid_in && last_beat && !full_reg;
    assign load  = (!core_valid_out || core_ready) &&
                   (count >= (AW+1)'(CORE_RATIO));

    assign wptr_next = wptr_reg + (wr_en ? (AW+1)'(1) : '0);
    assign rptr_next = rptr_reg + (load ? (AW+1)'(CORE_RATIO) : '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_reg[AW-1:0]] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            full_reg <= 1'b0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            full_reg <= (wptr_next[AW] != rptr_next[AW]) &&
                        (wptr_next[AW-1:0] == rptr_next[AW-1:0]);
        end
    end

    assign full = full_reg;

    // The group read wraps naturally because the index is only AW bits wide.
    // DEPTH is a multiple of CORE_RATIO, so a group never straddles the
    // write slot of a pending word.
    generate
        for (genvar gi = 0; gi < CORE_RATIO; gi++) begin : g_rd
            logic [AW-1:0] rd_idx;
            assign rd_idx = rptr_reg[AW-1:0] + AW'(gi);
            assign rd_word[gi*W +: W] = mem[rd_idx];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    logic              valid_reg;
    logic [CORE_W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= rd_word;
        end else if (core_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign core_valid_out = valid_reg;
    assign core_data_out  = data_reg;

    // ------------------------------------------------------------------
    // Credit decimation: CORE_RATIO words are credited per load. One token
    // is returned each time TOKEN_EVERY words have been accumulated.
    // ------------------------------------------------------------------
    logic [TCW-1:0] tok_cnt_reg;
    logic [TCW-1:0] tok_sum;
    logic           token_reg;

    assign tok_sum = tok_cnt_reg + TCW'(CORE_RATIO);

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt_reg <= '0;
            token_reg   <= 1'b0;
        end else if (load) begin
            if (tok_sum >= TCW'(TOKEN_EVERY)) begin
                tok_cnt_reg <= tok_sum - TCW'(TOKEN_EVERY);
                token_reg   <= 1'b1;
            end else begin
                tok_cnt_reg <= tok_sum;
                token_reg   <= 1'b0;
            end
        end else begin
            token_reg <= 1'b0;
        end
    end

    assign io_token_out = token_reg;

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef BSG_DS_RX_OVERFLOW_STICKY_EN
    logic overflow_reg;
    logic drop;

    assign drop = io_valid_in && last_beat && full_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_ds_rx_gather.sv
module tb_bsg_ds_rx_gather;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_valid;
    logic [7:0]  io_data;
    logic        core_ready;

    logic        valid_a, tok_a, full_a, ovf_a;
    logic [31:0] data_a;
    logic        valid_b, tok_b, full_b, ovf_b;
    logic [31:0] data_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_a[$];
    int          tokq_a[$];
    logic [31:0] got_b[$];
    int          tokq_b[$];

    always #5 clk = ~clk;

    // Default parameters
    bsg_ds_rx_gather u_a (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid),
        .io_data_in     (io_data),
        .core_ready     (core_ready),
        .core_valid_out (valid_a),
        .core_data_out  (data_a),
        .io_token_out   (tok_a),
        .full           (full_a),
        .overflow       (ovf_a)
    );

    // Small buffer for wrap-around
    bsg_ds_rx_gather #(.DEPTH(4)) u_b (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid),
        .io_data_in     (io_data),
        .core_ready     (core_ready),
        .core_valid_out (valid_b),
        .core_data_out  (data_b),
        .io_token_out   (tok_b),
        .full           (full_b),
        .overflow       (ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive the inputs for the coming posedge at the negedge, then
    // log the words handed over at that posedge and any token visible now.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        io_valid   = v;
        io_data    = d;
        core_ready = r;
        if (valid_a && r) got_a.push_back(data_a);
        if (tok_a) tokq_a.push_back(got_a.size());
        if (valid_b && r) got_b.push_back(data_b);
        if (tok_b) tokq_b.push_back(got_b.size());
        $display("cyc v=%0b d=%02h r=%0b | a: valid=%0b data=%08h tok=%0b full=%0b ovf=%0b | b: valid=%0b data=%08h tok=%0b",
                 v, d, r, valid_a, data_a, tok_a, full_a, ovf_a, valid_b, data_b, tok_b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        got_a.delete();
        tokq_a.delete();
        got_b.delete();
        tokq_b.delete();
    endtask

    function automatic logic [31:0] wexp(input int j);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*j);
        b1 = 8'(4*j + 1);
        b2 = 8'(4*j + 2);
        b3 = 8'(4*j + 3);
        return {b3, b2, b1, b0};
    endfunction

    logic exp_ovf;

    initial begin
        rst        = 1'b1;
        io_valid   = 1'b0;
        io_data    = 8'h00;
        core_ready = 1'b0;
`ifdef BSG_DS_RX_OVERFLOW_STICKY_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif

        // ---- reset defaults ----
        do_reset();
        cyc(1'b0, 8'h00, 1'b0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_data",  data_a, 32'h0);
        chk("rst_token", tok_a, 1'b0);
        chk("rst_full",  full_a, 1'b0);
        chk("rst_ovf",   ovf_a, 1'b0);

        // ---- single core word and latency ----
        do_reset();
        cyc(1'b1, 8'h11, 1'b1);
        cyc(1'b1, 8'h22, 1'b1);
        cyc(1'b1, 8'h33, 1'b1);
        cyc(1'b1, 8'h44, 1'b1);   // last beat is written at the next edge
        cyc(1'b0, 8'h00, 1'b1);
        chk("lat_valid_t1", valid_a, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("lat_valid_t2", valid_a, 1'b1);
        chk("lat_data_t2",  data_a, 32'h44332211);
        cyc(1'b0, 8'h00, 1'b1);
        chk("lat_valid_t3", valid_a, 1'b0);
        chk("single_ntok",  tokq_a.size(), 0);

        // ---- two core words, one token ----
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("two_nwords", got_a.size(), 2);
        if (got_a.size() == 2) begin
            chk("two_w0", got_a[0], 32'h04030201);
            chk("two_w1", got_a[1], 32'h08070605);
        end
        chk("two_ntok", tokq_a.size(), 1);
        if (tokq_a.size() == 1) chk("two_tok_pos", tokq_a[0], 2);

        // ---- fill to full, drop, then drain ----
        // With core_ready low the output register still takes the first
        // group, so the buffer fills after 66 words in total.
        do_reset();
        for (int i = 0; i < 130; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("fill_notfull_65", full_a, 1'b0);
        cyc(1'b1, 8'd130, 1'b0);
        cyc(1'b1, 8'd131, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("fill_full_66", full_a, 1'b1);
        chk("fill_ovf_pre", ovf_a, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        cyc(1'b1, 8'hEF, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("drop_full", full_a, 1'b1);
        chk("drop_ovf",  ovf_a, exp_ovf);
        for (int i = 0; i < 40; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("drain_nwords", got_a.size(), 33);
        for (int j = 0; j < got_a.size() && j < 33; j++) chk($sformatf("drain_w%0d", j), got_a[j], wexp(j));
        chk("drain_full",  full_a, 1'b0);
        chk("drain_valid", valid_a, 1'b0);
        chk("drain_ntok",  tokq_a.size(), 16);
        chk("drain_ovf_hold", ovf_a, exp_ovf);

        // ---- wrap-around on DEPTH=4 ----
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("wrap_nwords", got_b.size(), 10);
        for (int j = 0; j < got_b.size() && j < 10; j++) chk($sformatf("wrap_w%0d", j), got_b[j], wexp(j));
        chk("wrap_ntok", tokq_b.size(), 5);
        for (int k = 0; k < tokq_b.size() && k < 5; k++) chk($sformatf("wrap_tok%0d", k), tokq_b[k], 2*(k+1));
        chk("wrap_ovf", ovf_b, 1'b0);

        // ---- reset discards a partial word ----
        do_reset();
        cyc(1'b1, 8'h55, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        got_a.delete();
        tokq_a.delete();
        cyc(1'b1, 8'hAA, 1'b1);
        cyc(1'b1, 8'hBB, 1'b1);
        cyc(1'b1, 8'hCC, 1'b1);
        cyc(1'b1, 8'hDD, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("partial_nwords", got_a.size(), 1);
        if (got_a.size() >= 1) chk("partial_w0", got_a[0], 32'hDDCCBBAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
